nibble_byte_fifo: RTL

NIBBLE_BYTE_FIFO -- requirements
Module: nibble_byte_fifo

---
 rtl/nibble_byte_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nibble_byte_fifo.sv
// nibble_byte_fifo: packs pairs of nibbles into bytes and stores them in a small FIFO.
// The valid and toggle pins are asynchronous levels. Each pin goes through a
// two-flop synchroniser and a rising-edge detector. Each valid edge offers one
// nibble, and each toggle edge pops the head byte.
// Optional feature: define NIBFIFO_OVF_FLAG_EN to get a sticky overflow flag on ovf.
module nibble_byte_fifo #(
    parameter int NIB_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NIB_W-1:0]           din,
    input  logic                       valid,
    input  logic                       toggle,
    output logic [2*NIB_W-1:0]         dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0] HI_WAIT = 1'b0;
    localparam logic [0:0] LO_WAIT = 1'b1;

    logic [2:0]         v_sync, t_sync;
    logic               live0, live1;
    logic               v_arm, t_arm;
    logic               vstb, tstb;
    logic [0:0]         state;
    logic [NIB_W-1:0]   upper;
    logic               push, push_ok, pop_ok;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [2*NIB_W-1:0] mem [DEPTH];

    // Synchronise both pins and arm each edge detector only after a real low
    // sample, so a pin already high at reset release never produces a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_sync <= '0;
            t_sync <= '0;
            live0  <= 1'b0;
            live1  <= 1'b0;
            v_arm  <= 1'b0;
            t_arm  <= 1'b0;
        end else begin
            v_sync <= {v_sync[1:0], valid};
            t_sync <= {t_sync[1:0], toggle};
            live0  <= 1'b1;
            live1  <= live0;
            if (live1 && !v_sync[1]) v_arm <= 1'b1;
            if (live1 && !t_sync[1]) t_arm <= 1'b1;
        end
    end

    // Rising-edge strobes; FIFO pop and push qualification.
    always_comb begin
        vstb    = v_sync[1] & ~v_sync[2] & v_arm;
        tstb    = t_sync[1] & ~t_sync[2] & t_arm;
        push    = (state == LO_WAIT) && vstb;
        pop_ok  = tstb && (count != '0);
        push_ok = push && (!full || pop_ok);
    end

    // Assembler: the first nibble becomes the upper half, the second completes the byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HI_WAIT;
            upper <= '0;
        end else if (vstb) begin
            if (state == HI_WAIT) begin
                upper <= din;
                state <= LO_WAIT;
            end else begin
                state <= HI_WAIT;
            end
        end
    end

    // Pointers and occupancy; a push into a full FIFO without a pop is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; its contents are hidden while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {upper, din};
    end

    // Registered head byte, lagging pointer and count changes by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dout <= '0;
        else       dout <= empty ? '0 : mem[rd_ptr];
    end

    // Status flags derived from the registered count.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
    end

`ifdef NIBFIFO_OVF_FLAG_EN
    logic ovf_q;

    // Sticky overflow flag, set by a dropped push and held until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    ovf_q <= 1'b0;
        else if (push && !push_ok)    ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
